io_bank_cfg_ctrl: RTL and testbench

- Parametrised multi-pad I/O tile for the 2x2 eFPGA.
- Each of NUM_PADS GPIO pads has its own per-pad configuration field:
  - bit0 DIR (1 = pad is input / high-Z, 0 = pad driven by fabric).
  - bit1 INV_IN (invert the pad-to-fabric path).
- Configuration arrives on the ccff daisy chain. It is captured into a shadow register only after a length-checked shift completes, so pad directions never toggle while bits ripple through the chain.
- Configuration done/error status is reported to the programming controller.

---
 rtl/io_bank_cfg_ctrl.sv | 99 +++++++++
 tb/tb_io_bank_cfg_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/io_bank_cfg_ctrl.sv
// rtl/io_bank_cfg_ctrl.sv - GPIO pad bank with length-checked ccff configuration capture
// Config shifts through chain and is only copied to the shadow register after an exact-length burst.
module io_bank_cfg_ctrl #(
  parameter int NUM_PADS   = 4,
  parameter int CFG_BITS   = 2,
  parameter int EXPECT_LEN = NUM_PADS * CFG_BITS,
  parameter bit RESET_DIR  = 1'b1
) (
  input  logic                prog_clk,
  input  logic                pReset,
  inout  wire  [NUM_PADS-1:0] gfpga_pad_GPIO_PAD,
  input  logic [NUM_PADS-1:0] iopad_outpad,
  output logic [NUM_PADS-1:0] iopad_inpad,
  input  logic                ccff_head,
  input  logic                ccff_en,
  output logic                ccff_tail,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic [NUM_PADS-1:0] cfg_dir
);

  localparam int CHAIN_LEN = NUM_PADS * CFG_BITS;
  localparam int CNT_W     = $clog2(EXPECT_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(EXPECT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EXPECT_LEN + 1);

  function automatic logic [CHAIN_LEN-1:0] shd_reset_value();
    logic [CHAIN_LEN-1:0] r;
    r = '0;
    for (int p = 0; p < NUM_PADS; p++) r[p*CFG_BITS] = RESET_DIR;
    return r;
  endfunction

  localparam logic [CHAIN_LEN-1:0] SHD_RST = shd_reset_value();

  typedef enum logic [2:0] {IDLE, SHIFT, COMMIT, DONE, ERR} state_t;

  state_t               state;
  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] shd;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] chain_shifted;

  assign chain_shifted = {chain[CHAIN_LEN-2:0], ccff_head};
  assign ccff_tail     = chain[CHAIN_LEN-1];

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state    <= IDLE;
      chain    <= '0;
      cnt      <= '0;
      shd      <= SHD_RST;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (ccff_en) begin
            chain    <= chain_shifted;
            cnt      <= CNT_W'(1);
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            state    <= SHIFT;
          end else if (state == DONE) begin
            cfg_done <= 1'b1;
          end
        end
        SHIFT: begin
          if (ccff_en) begin
            chain <= chain_shifted;
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end else if (cnt == CNT_EXP) begin
            state <= COMMIT;
          end else begin
            cfg_err <= 1'b1;
            state   <= ERR;
          end
        end
        COMMIT: begin
          // ccff_en is deliberately ignored here so the committed image is exactly the checked one
          shd   <= chain;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic dir;
    logic inv_in;
    assign dir                   = shd[p*CFG_BITS];
    assign inv_in                = shd[p*CFG_BITS+1];
    assign cfg_dir[p]            = dir;
    assign gfpga_pad_GPIO_PAD[p] = dir ? 1'bz : iopad_outpad[p];
    assign iopad_inpad[p]        = gfpga_pad_GPIO_PAD[p] ^ inv_in;
  end

endmodule

// File: tb/tb_io_bank_cfg_ctrl.sv
// tb/tb_io_bank_cfg_ctrl.sv - directed scoreboard bench for io_bank_cfg_ctrl
module tb_io_bank_cfg_ctrl;

  logic       prog_clk = 1'b0;
  logic       pReset;
  wire  [3:0] pad;
  logic [3:0] iopad_outpad;
  logic [3:0] iopad_inpad;
  logic       ccff_head;
  logic       ccff_en;
  logic       ccff_tail;
  logic       cfg_done;
  logic       cfg_err;
  logic [3:0] cfg_dir;
  logic [3:0] ext_en;
  logic [3:0] ext_drv;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 prog_clk = ~prog_clk;

  for (genvar i = 0; i < 4; i++) begin : g_ext
    assign pad[i] = ext_en[i] ? ext_drv[i] : 1'bz;
  end

  io_bank_cfg_ctrl #(.NUM_PADS(4)) dut (
    .prog_clk          (prog_clk),
    .pReset            (pReset),
    .gfpga_pad_GPIO_PAD(pad),
    .iopad_outpad      (iopad_outpad),
    .iopad_inpad       (iopad_inpad),
    .ccff_head         (ccff_head),
    .ccff_en           (ccff_en),
    .ccff_tail         (ccff_tail),
    .cfg_done          (cfg_done),
    .cfg_err           (cfg_err),
    .cfg_dir           (cfg_dir)
  );

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed %0h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  // bits[n-1] goes in first, so an 8-bit image lands with bits[k] in chain[k]
  task automatic shift_bits(input logic [15:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      ccff_en   = 1'b1;
      ccff_head = bits[n-1-k];
      step();
    end
  endtask

  initial begin
    pReset       = 1'b0;
    ccff_en      = 1'b0;
    ccff_head    = 1'b0;
    iopad_outpad = 4'b0000;
    ext_en       = 4'b1111;
    ext_drv      = 4'b1010;
    step();
    step();
    pReset = 1'b1;

    expect_val("rst_dir", 4'b1111);   check(cfg_dir);
    expect_val("rst_inpad", 4'b1010); check(iopad_inpad);
    expect_val("rst_tail", 1'b0);     check(ccff_tail);
    expect_val("rst_done", 1'b0);     check(cfg_done);
    expect_val("rst_err", 1'b0);      check(cfg_err);

    // pad0 drive, pad1 input inverted, pads 2-3 input: image 8'h5C
    ext_en  = 4'b1110;
    ext_drv = 4'b1000;
    shift_bits(16'h005C, 8);
    ccff_en = 1'b0;
    expect_val("good_dir_e0", 4'b1111); check(cfg_dir);
    step();
    expect_val("good_dir_e1", 4'b1111); check(cfg_dir);
    expect_val("good_done_e1", 1'b0);   check(cfg_done);
    step();
    expect_val("good_dir_e2", 4'b1110); check(cfg_dir);
    expect_val("good_done_e2", 1'b0);   check(cfg_done);
    step();
    expect_val("good_done_e3", 1'b1);   check(cfg_done);
    expect_val("good_err_e3", 1'b0);    check(cfg_err);
    iopad_outpad = 4'b0001;
    #1;
    expect_val("good_pad0", 1'b1);      check(pad[0]);
    expect_val("good_inpad", 4'b1011);  check(iopad_inpad);

    shift_bits(16'h007F, 7);
    ccff_en = 1'b0;
    step();
    expect_val("short_err", 1'b1);      check(cfg_err);
    expect_val("short_done", 1'b0);     check(cfg_done);
    step();
    step();
    expect_val("short_dir", 4'b1110);   check(cfg_dir);
    expect_val("short_inpad", 4'b1011); check(iopad_inpad);

    shift_bits(16'h0080, 8);
    expect_val("over_tail8", 1'b1);     check(ccff_tail);
    shift_bits(16'h0000, 1);
    expect_val("over_tail9", 1'b0);     check(ccff_tail);
    ccff_en = 1'b0;
    step();
    expect_val("over_err", 1'b1);       check(cfg_err);
    step();
    step();
    expect_val("over_dir", 4'b1110);    check(cfg_dir);
    expect_val("over_done", 1'b0);      check(cfg_done);

    shift_bits(16'h000F, 4);
    pReset = 1'b0;
    step();
    pReset  = 1'b1;
    ccff_en = 1'b0;
    expect_val("mid_dir", 4'b1111);     check(cfg_dir);
    expect_val("mid_done", 1'b0);       check(cfg_done);
    expect_val("mid_err", 1'b0);        check(cfg_err);
    expect_val("mid_tail", 1'b0);       check(ccff_tail);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_val("mid_quiet", 2'b00);   check({cfg_done, cfg_err});
    end

    shift_bits(16'h005C, 8);
    ccff_en = 1'b0;
    step();
    step();
    step();
    expect_val("b2b_done_a", 1'b1);     check(cfg_done);
    // second image 8'h63: pad0 input inv, pad1 drive, pad2 drive inv, pad3 input
    ext_en       = 4'b1001;
    ext_drv      = 4'b0001;
    iopad_outpad = 4'b0111;
    shift_bits(16'h0063 >> 7, 1);
    expect_val("b2b_done_clr", 1'b0);   check(cfg_done);
    shift_bits(16'h0063, 7);
    ccff_en = 1'b0;
    step();
    step();
    expect_val("b2b_dir", 4'b1001);     check(cfg_dir);
    step();
    expect_val("b2b_done_b", 1'b1);     check(cfg_done);
    expect_val("b2b_pads", 2'b11);      check(pad[2:1]);
    expect_val("b2b_inpad", 4'b0010);   check(iopad_inpad);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
